// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into key events, tracks the held key, flags auto-repeat and counts presses.
module ps2_scancode_decoder #(
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic               ready,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic               evt_valid,
  output logic               evt_break,
  output logic               evt_ext,
  output logic               evt_repeat,
  output logic [7:0]         evt_code,
  output logic [7:0]         evt_ascii,
  output logic               held_valid,
  output logic [7:0]         held_code,
  output logic [7:0]         held_ascii,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_seen
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_GAP
  } state_t;

  state_t             state_q;
  logic [GAP_W-1:0]   gap_q;
  logic               nextdata_n_q;
  logic               ext_pend_q;
  logic               brk_pend_q;
  logic               evt_valid_q;
  logic               evt_break_q;
  logic               evt_ext_q;
  logic               evt_repeat_q;
  logic [7:0]         evt_code_q;
  logic               held_valid_q;
  logic               held_ext_q;
  logic [7:0]         held_code_q;
  logic [COUNT_W-1:0] press_count_q;
  logic               ovf_seen_q;

  logic               key_match_d;
  logic [COUNT_W-1:0] press_count_d;
  logic [7:0]         evt_ascii_d;
  logic [7:0]         held_ascii_d;

  function automatic logic [7:0] code_to_ascii(input logic [7:0] code);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = 8'h61;
      8'h32: ch = 8'h62;
      8'h21: ch = 8'h63;
      8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;
      8'h2B: ch = 8'h66;
      8'h34: ch = 8'h67;
      8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;
      8'h3B: ch = 8'h6A;
      8'h42: ch = 8'h6B;
      8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;
      8'h31: ch = 8'h6E;
      8'h44: ch = 8'h6F;
      8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;
      8'h2D: ch = 8'h72;
      8'h1B: ch = 8'h73;
      8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;
      8'h2A: ch = 8'h76;
      8'h1D: ch = 8'h77;
      8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;
      8'h1A: ch = 8'h7A;
      8'h45: ch = 8'h30;
      8'h16: ch = 8'h31;
      8'h1E: ch = 8'h32;
      8'h26: ch = 8'h33;
      8'h25: ch = 8'h34;
      8'h2E: ch = 8'h35;
      8'h36: ch = 8'h36;
      8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38;
      8'h46: ch = 8'h39;
      8'h29: ch = 8'h20;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  // The incoming byte is compared against the held key with the pending E0 flag as its ext bit.
  always_comb begin
    key_match_d   = held_valid_q && (held_ext_q == ext_pend_q) && (held_code_q == data);
    press_count_d = press_count_q + COUNT_W'(1);
    evt_ascii_d   = evt_ext_q  ? 8'h00 : code_to_ascii(evt_code_q);
    held_ascii_d  = held_ext_q ? 8'h00 : code_to_ascii(held_code_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gap_q         <= '0;
      nextdata_n_q  <= 1'b1;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      evt_valid_q   <= 1'b0;
      evt_break_q   <= 1'b0;
      evt_ext_q     <= 1'b0;
      evt_repeat_q  <= 1'b0;
      evt_code_q    <= '0;
      held_valid_q  <= 1'b0;
      held_ext_q    <= 1'b0;
      held_code_q   <= '0;
      press_count_q <= '0;
      ovf_seen_q    <= 1'b0;
    end else begin
      if (overflow) begin
        ovf_seen_q <= 1'b1;
      end
      evt_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (ready) begin
            nextdata_n_q <= 1'b0;
            state_q      <= S_POP;
            if (data == 8'hE0) begin
              ext_pend_q <= 1'b1;
            end else if (data == 8'hF0) begin
              brk_pend_q <= 1'b1;
            end else begin
              evt_valid_q <= 1'b1;
              evt_code_q  <= data;
              evt_ext_q   <= ext_pend_q;
              evt_break_q <= brk_pend_q;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
              if (!brk_pend_q) begin
                evt_repeat_q <= key_match_d;
                if (!key_match_d) begin
                  press_count_q <= press_count_d;
                  held_valid_q  <= 1'b1;
                  held_ext_q    <= ext_pend_q;
                  held_code_q   <= data;
                end
              end else begin
                evt_repeat_q <= 1'b0;
                if (key_match_d) begin
                  held_valid_q <= 1'b0;
                end
              end
            end
          end
        end
        S_POP: begin
          nextdata_n_q <= 1'b1;
          gap_q        <= GAP_W'(GAP_CYCLES - 1);
          state_q      <= S_GAP;
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign evt_valid   = evt_valid_q;
  assign evt_break   = evt_break_q;
  assign evt_ext     = evt_ext_q;
  assign evt_repeat  = evt_repeat_q;
  assign evt_code    = evt_code_q;
  assign evt_ascii   = evt_ascii_d;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign held_ascii  = held_ascii_d;
  assign press_count = press_count_q;
  assign ovf_seen    = ovf_seen_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: a queue-backed FIFO feeds bytes, and a key-level
// reference model predicts every event, held-key state and press count.
module tb_ps2_scancode_decoder;

  localparam int unsigned COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         data = 8'h00;
  logic               ready = 1'b0;
  logic               overflow = 1'b0;
  logic               nextdata_n;
  logic               evt_valid;
  logic               evt_break;
  logic               evt_ext;
  logic               evt_repeat;
  logic [7:0]         evt_code;
  logic [7:0]         evt_ascii;
  logic               held_valid;
  logic [7:0]         held_code;
  logic [7:0]         held_ascii;
  logic [COUNT_W-1:0] press_count;
  logic               ovf_seen;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(
    .COUNT_W    (COUNT_W),
    .GAP_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .evt_valid   (evt_valid),
    .evt_break   (evt_break),
    .evt_ext     (evt_ext),
    .evt_repeat  (evt_repeat),
    .evt_code    (evt_code),
    .evt_ascii   (evt_ascii),
    .held_valid  (held_valid),
    .held_code   (held_code),
    .held_ascii  (held_ascii),
    .press_count (press_count),
    .ovf_seen    (ovf_seen)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Key-level reference model
  typedef struct {
    logic               brk;
    logic               ext;
    logic               rpt;
    logic [7:0]         code;
    logic [7:0]         ascii;
    logic               hv;
    logic [7:0]         hcode;
    logic [7:0]         hascii;
    logic [COUNT_W-1:0] cnt;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  fifo[$];
  logic        m_ext, m_brk, m_hv, m_hext;
  logic [7:0]  m_hcode;
  int unsigned m_cnt;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};

  function automatic logic [7:0] ref_ascii(input logic ext, input logic [7:0] code);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++) if (letter_codes[i] == code) return 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == code) return 8'(8'h30 + i);
    if (code == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_hv = 1'b0; m_hext = 1'b0; m_hcode = 8'h00; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t  e;
    logic same;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      same    = m_hv && (m_hext == m_ext) && (m_hcode == b);
      e.brk   = m_brk;
      e.ext   = m_ext;
      e.code  = b;
      e.ascii = ref_ascii(m_ext, b);
      e.rpt   = !m_brk && same;
      if (!m_brk && !same) begin
        m_cnt = (m_cnt + 1) % (1 << COUNT_W);
        m_hv = 1'b1; m_hext = m_ext; m_hcode = b;
      end else if (m_brk && same) begin
        m_hv = 1'b0;
      end
      e.hv     = m_hv;
      e.hcode  = m_hcode;
      e.hascii = ref_ascii(m_hext, m_hcode);
      e.cnt    = COUNT_W'(m_cnt);
      exp_q.push_back(e);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
  endtask

  // Receiver FIFO: pops its head when the pop strobe is seen low
  always @(negedge clk) begin
    if (!rst && !nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
    ready = (fifo.size() > 0);
    data  = ready ? fifo[0] : 8'h00;
  end

  int unsigned cyc = 0, pops = 0, evts = 0, rpts = 0;
  int unsigned pop_cyc[$];
  logic        prev_low = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_low = 1'b0;
    end else begin
      cyc++;
      if (!nextdata_n) begin
        chk("pop_single_cycle", {31'b0, prev_low}, 32'd0);
        pops++;
        pop_cyc.push_back(cyc);
      end
      prev_low = !nextdata_n;
      if (evt_valid) begin
        ev_t e;
        evts++;
        if (evt_repeat) rpts++;
        chk("evt_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("evt_code",    evt_code,    e.code);
          chk("evt_break",   evt_break,   e.brk);
          chk("evt_ext",     evt_ext,     e.ext);
          chk("evt_repeat",  evt_repeat,  e.rpt);
          chk("evt_ascii",   evt_ascii,   e.ascii);
          chk("held_valid",  held_valid,  e.hv);
          chk("held_code",   held_code,   e.hcode);
          chk("held_ascii",  held_ascii,  e.hascii);
          chk("press_count", press_count, e.cnt);
        end
      end
    end
  end

  task automatic drain();
    int unsigned n = 0;
    while (fifo.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", fifo.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    fifo.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_nextdata_n",  nextdata_n,  32'd1);
    chk("rst_evt_valid",   evt_valid,   32'd0);
    chk("rst_evt_break",   evt_break,   32'd0);
    chk("rst_evt_ext",     evt_ext,     32'd0);
    chk("rst_evt_repeat",  evt_repeat,  32'd0);
    chk("rst_evt_code",    evt_code,    32'd0);
    chk("rst_evt_ascii",   evt_ascii,   32'd0);
    chk("rst_held_valid",  held_valid,  32'd0);
    chk("rst_held_code",   held_code,   32'd0);
    chk("rst_press_count", press_count, 32'd0);
    chk("rst_ovf_seen",    ovf_seen,    32'd0);
  endtask

  initial begin
    int unsigned p0, e0, r0, base, k;
    logic [7:0]  pool [8];
    logic [7:0]  c;
    logic        ex, bk;

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    #1 rst = 1'b0;

    // make / break of 'a'
    p0 = pops;
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("t1_pops",        pops - p0,   32'd3);
    chk("t1_held_valid",  held_valid,  32'd0);
    chk("t1_held_code",   held_code,   32'h1C);
    chk("t1_press_count", press_count, 32'd1);
    chk("t1_evt_hold",    evt_ascii,   32'h61);

    // auto-repeat filtering
    do_reset();
    r0 = rpts;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("t2_repeats",     rpts - r0,   32'd2);
    chk("t2_press_count", press_count, 32'd1);
    chk("t2_held_valid",  held_valid,  32'd0);

    // extended key
    do_reset();
    p0 = pops; e0 = evts;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    chk("t3_pops",      pops - p0, 32'd5);
    chk("t3_events",    evts - e0, 32'd2);
    chk("t3_evt_ext",   evt_ext,   32'd1);
    chk("t3_evt_break", evt_break, 32'd1);
    chk("t3_evt_ascii", evt_ascii, 32'd0);

    // back-to-back pops with ready held high
    do_reset();
    base = pop_cyc.size();
    push(8'h15); push(8'h1D); push(8'h24); push(8'h2D); push(8'h2C);
    push(8'h35); push(8'h3C); push(8'h43); push(8'h44); push(8'h4D);
    drain();
    chk("t4_pops", pop_cyc.size() - base, 32'd10);
    for (int i = base + 1; i < pop_cyc.size(); i++)
      chk("t4_spacing", pop_cyc[i] - pop_cyc[i-1], 32'd3);
    chk("t4_press_count", press_count, 32'd10);

    // break of a non-held key
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h32);
    drain();
    chk("t5_held_after_brk", held_valid, 32'd1);
    push(8'h32);
    drain();
    chk("t5_held_code",   held_code,   32'h32);
    chk("t5_press_count", press_count, 32'd2);

    // counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) push((i % 2) ? 8'h32 : 8'h1C);
    drain();
    chk("t6_count_ff", press_count, 32'hFF);
    push(8'h32);
    drain();
    chk("t6_count_wrap", press_count, 32'h00);

    // overflow is sticky
    @(negedge clk); #1 overflow = 1'b1;
    @(negedge clk); #1 overflow = 1'b0;
    @(negedge clk);
    chk("t7_ovf_set", ovf_seen, 32'd1);
    repeat (5) @(negedge clk);
    chk("t7_ovf_sticky", ovf_seen, 32'd1);

    // reset during a pop with a break prefix pending
    push(8'hF0);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (!nextdata_n) break;
    end
    chk("t8_pop_seen", nextdata_n, 32'd0);
    #1 rst = 1'b1;
    fifo.delete();
    model_reset();
    @(negedge clk);
    check_reset_state();
    #1 rst = 1'b0;
    push(8'h1C);
    drain();
    chk("t8_make_break", evt_break,   32'd0);
    chk("t8_make_held",  held_valid,  32'd1);
    chk("t8_make_count", press_count, 32'd1);

    // randomized key traffic
    do_reset();
    pool = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'h45, 8'h16, 8'h5A, 8'h46};
    for (int i = 0; i < 60; i++) begin
      c = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) c = 8'($urandom_range(1, 8'hDF));
      ex = ($urandom_range(0, 3) == 0);
      bk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if (ex) push(8'hE0);
        if (bk) push(8'hF0);
      end else begin
        if (bk) push(8'hF0);
        if (ex) push(8'hE0);
      end
      if (ex && $urandom_range(0, 3) == 0) push(8'hE0);
      push(c);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();

    chk("events_all_seen", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream from the PS/2 keyboard receiver FIFO through its ready / nextdata_n pop handshake.
- Parses set-2 prefixes (E0 extended, F0 break) into key events, tracks the currently held key, filters auto-repeat, counts distinct presses and maps common keys to ASCII.
- Outputs feed the seven-segment display logic.

Parameters:
- COUNT_W, 8, width of the press counter.
- GAP_CYCLES, 1, idle cycles after each pop before ready is re-sampled (min 1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data  input  8  FIFO head byte from the PS/2 receiver.
- ready  input  1  FIFO non-empty; data valid.
- overflow  input  1  receiver FIFO overflow flag.
- nextdata_n  output  1  active-low pop strobe to the receiver FIFO.
- evt_valid  output  1  one-cycle pulse: new key event on the evt_* outputs.
- evt_break  output  1  event is a release (F0-prefixed).
- evt_ext  output  1  event is extended (E0-prefixed).
- evt_repeat  output  1  event is an auto-repeat make of the held key.
- evt_code  output  8  scan code of the event, prefix bytes excluded.
- evt_ascii  output  8  ASCII of evt_code; 0x00 if unmapped or extended.
- held_valid  output  1  a key is currently held.
- held_code  output  8  code of the held or last-held key.
- held_ascii  output  8  ASCII of held_code.
- press_count  output  COUNT_W  number of distinct presses.
- ovf_seen  output  1  sticky: overflow was observed high.

Behaviour:
- Reset (rst high at posedge): takes priority over everything, including mid-pop and mid-prefix.
  - Values: nextdata_n=1, evt_valid=0, all evt_*/held_* = 0, press_count=0, ovf_seen=0, pending flags cleared, state=IDLE.
- Handshake FSM: IDLE -> POP -> GAP(xGAP_CYCLES) -> IDLE.
  - IDLE: if ready=1 at posedge T, latch data; next state POP. nextdata_n is low for exactly the cycle T+1.
  - POP: nextdata_n=1 from T+2; state goes to GAP.
  - GAP: ready and data ignored; after GAP_CYCLES cycles return to IDLE. With the default, ready is next sampled at T+3.
  - ready=0 in IDLE: no action, nextdata_n stays high.
  - One byte per pop; never two pops without an intervening GAP.
- Byte parsing happens on the latched byte. Results are registered and visible in cycle T+1, together with nextdata_n low.
  - 0xE0: set ext_pend; no event.
  - 0xF0: set brk_pend; no event.
  - Any other byte: emit an event for exactly one cycle.
    - evt_valid=1, evt_code=byte, evt_ext=ext_pend, evt_break=brk_pend.
    - Both pending flags are cleared in the same cycle.
  - Prefix order is free: E0 F0 xx and F0 E0 xx are equivalent.
  - Repeated prefixes are idempotent.
- Make event (brk_pend=0):
  - If held_valid=1 and {evt_ext, evt_code} equals the held key: evt_repeat=1; press_count unchanged.
  - Otherwise: evt_repeat=0, press_count increments, held_valid=1, held_code/held ext updated.
- Break event:
  - If it matches the held key: held_valid=0; held_code is retained.
  - If it does not match: held state unchanged.
  - evt_repeat=0 for all breaks.
- press_count wraps modulo 2^COUNT_W (0xFF -> 0x00 for the default).
- evt_* holds its last values when evt_valid=0.
- ASCII map is combinational from the code and forced to 0x00 when ext=1. Table (code: char):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Space: 29 -> 0x20.
  - All others -> 0x00.
- ovf_seen is set on any cycle with overflow=1 and cleared only by rst. Parsing is unaffected by overflow.

Test Plan:
- Reset then FIFO bytes 1C, F0, 1C -> events (make 1C, ascii 0x61, press_count=1, held_valid=1), then (break 1C, held_valid=0, held_code=1C). Exactly 3 nextdata_n low pulses, each followed by >=1 high cycle.
- Bytes 1C, 1C, 1C, F0, 1C -> three makes: first evt_repeat=0, next two evt_repeat=1. press_count=1 and held_valid=0 at end.
- Bytes E0, 75, E0, F0, 75 -> make with evt_ext=1, evt_ascii=0x00; then break with evt_ext=1. Only 2 evt_valid pulses for 5 pops.
- ready held high continuously with 10 bytes queued -> pops are spaced one per 3 cycles at GAP_CYCLES=1. No byte is skipped or duplicated (checked against the queued sequence).
- Make 1C; break 32 (non-held); make 32 -> held_valid stays 1 after the break of 32, then held_code=32 and press_count=2. Preload 255 presses -> next press yields press_count=0x00.
- Assert rst in the cycle nextdata_n is low, with brk_pend set -> next cycle nextdata_n=1 and all outputs 0. A following byte 1C is decoded as a make, not a break. overflow pulse -> ovf_seen=1 until rst.
